// File: rtl/data_mem_port.sv
// Data RAM endpoint for the load/store path: one request in flight, byte-lane stores, MSB-aligned load data.
// Optional macro DATA_MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into access faults.
`ifndef FUNCT3_WIDTH
`define FUNCT3_WIDTH 3
`endif

module data_mem_port #(
  parameter int N      = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [`FUNCT3_WIDTH-1:0] req_funct3,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [N-1:0]             req_wdata,
  output logic                     rsp_valid,
  output logic [N-1:0]             rsp_rdata,
  output logic                     rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                     state;
  logic                       ready_q;
  logic                       valid_q;
  logic                       we_q;
  logic [`FUNCT3_WIDTH-1:0]   f3_q;
  logic [ADDR_W-1:0]          addr_q;
  logic [N-1:0]               wdata_q;

  logic [N-1:0]               mem [DEPTH];

  logic [IDX_W-1:0]           idx;
  logic [1:0]                 lane;
  logic [3:0]                 be;
  logic [N-1:0]               wdata_rep;
  logic [N-1:0]               word;
  logic [N-1:0]               rdata_al;
  logic                       legal;
  logic                       range_err;
  logic                       misalign;
  logic                       err;

  assign idx       = addr_q[IDX_W+1:2];
  assign word      = mem[idx];
  assign range_err = |addr_q[ADDR_W-1:IDX_W+2];
  assign err       = !legal || range_err || misalign;

  // funct3[1:0] encodes the access size for every legal code; bit 2 is the unsigned-load flag
  always_comb begin
    legal     = 1'b0;
    lane      = addr_q[1:0];
    be        = 4'b0000;
    wdata_rep = wdata_q;
    rdata_al  = word;
    case (f3_q)
      `FUNCT3_WIDTH'(0), `FUNCT3_WIDTH'(1), `FUNCT3_WIDTH'(2): legal = 1'b1;
      `FUNCT3_WIDTH'(4), `FUNCT3_WIDTH'(5):                    legal = !we_q;
      default:                                                 legal = 1'b0;
    endcase
    case (f3_q[1:0])
      2'b00: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{wdata_q[7:0]}};
        rdata_al  = {word[{lane, 3'b000} +: 8], 24'h000000};
      end
      2'b01: begin
        lane      = addr_q[1:0] & 2'b10;
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_q[15:0]}};
        rdata_al  = {word[{lane[1], 4'b0000} +: 16], 16'h0000};
      end
      default: begin
        lane      = 2'b00;
        be        = 4'b1111;
        wdata_rep = wdata_q;
        rdata_al  = word;
      end
    endcase
  end

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  assign misalign = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                    ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Outputs are gated by rst so a reset during RESP never presents a response
  assign req_ready = ready_q & ~rst;
  assign rsp_valid = valid_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_q   <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            ready_q <= 1'b0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          valid_q   <= 1'b1;
          rsp_err   <= err;
          rsp_rdata <= (err || we_q) ? '0 : rdata_al;
          state     <= RESP;
        end
        RESP: begin
          valid_q   <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          ready_q   <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  // RAM contents survive reset; only the write of an abandoned store is blocked
  always_ff @(posedge clk) begin
    if (!rst && state == ACCESS && we_q && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_port.sv
// Scoreboard bench for data_mem_port: directed loads/stores, faults, back-to-back accepts and mid-access reset.
// Expectations follow DATA_MEM_MISALIGN_TRAP_EN when it is defined for the build.
module tb_data_mem_port;

  localparam int DEPTH = 1024;

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cycle = 0;
  int   n_compared = 0;
  int   n_mismatch = 0;

  data_mem_port #(.N(32), .DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the accepting rising edge
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input logic exp_err, input bit hold, output int acc);
    int waited;
    exp_t e;
    waited     = 0;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      n_compared++;
      n_mismatch++;
      $display("[TB] FAIL accept_timeout: req_ready got 0 expected 1 for addr 0x%08h", addr);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc     = cycle + 1;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.acc   = acc;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      n_compared++;
      n_mismatch++;
      $display("[TB] FAIL drain_timeout: pending got %0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every response pops the oldest expectation, including a latency check
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        n_compared++;
        n_mismatch++;
        $display("[TB] FAIL unexpected_rsp: rsp_valid got 1 expected 0 at cycle %0d", cycle);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("rsp_rdata", rsp_rdata, e.rdata);
        checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        checkOutput("rsp_latency", 32'(cycle + 1 - e.acc), 32'd2);
      end
    end
  end

  initial begin
    int a0, a1, a2;
    rst        = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    req_wdata  = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    checkOutput("ready_in_reset", {31'b0, req_ready}, 32'd0);
    req_valid = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("reset_rdata", rsp_rdata, 32'd0);
    checkOutput("reset_err", {31'b0, rsp_err}, 32'd0);

    applyStimulus(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, a0);
    applyStimulus(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, a0);
    applyStimulus(1, 3'b000, 32'h11, 32'h000000AA, 32'h0, 0, 0, a0);
    applyStimulus(0, 3'b010, 32'h10, 32'h0, 32'hDEADAAEF, 0, 0, a0);
    applyStimulus(0, 3'b000, 32'h11, 32'h0, 32'hAA000000, 0, 0, a0);
    applyStimulus(0, 3'b100, 32'h13, 32'h0, 32'hDE000000, 0, 0, a0);
    applyStimulus(1, 3'b001, 32'h12, 32'h00001234, 32'h0, 0, 0, a0);
    applyStimulus(0, 3'b001, 32'h12, 32'h0, 32'h12340000, 0, 0, a0);
    applyStimulus(0, 3'b010, 32'h10, 32'h0, 32'h1234AAEF, 0, 0, a0);
    applyStimulus(0, 3'b101, 32'h10, 32'h0, 32'hAAEF0000, 0, 0, a0);
    applyStimulus(0, 3'b000, 32'h10, 32'h0, 32'hEF000000, 0, 0, a0);

    // Misaligned accesses: fault with the trap, low bits ignored without it
    applyStimulus(0, 3'b010, 32'h11, 32'h0, TRAP ? 32'h0 : 32'h1234AAEF, TRAP, 0, a0);
    applyStimulus(0, 3'b001, 32'h13, 32'h0, TRAP ? 32'h0 : 32'h12340000, TRAP, 0, a0);
    applyStimulus(1, 3'b010, 32'h14, 32'h00000000, 32'h0, 0, 0, a0);
    applyStimulus(1, 3'b001, 32'h17, 32'h0000BEEF, 32'h0, TRAP, 0, a0);
    applyStimulus(0, 3'b010, 32'h14, 32'h0, TRAP ? 32'h0 : 32'hBEEF0000, 0, 0, a0);

    // Illegal funct3 and out-of-range addresses fault and leave RAM untouched
    applyStimulus(1, 3'b011, 32'h10, 32'hFFFFFFFF, 32'h0, 1, 0, a0);
    applyStimulus(1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1, 0, a0);
    applyStimulus(0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 0, a0);
    applyStimulus(0, 3'b110, 32'h10, 32'h0, 32'h0, 1, 0, a0);
    applyStimulus(1, 3'b010, 32'(4*DEPTH), 32'hFFFFFFFF, 32'h0, 1, 0, a0);
    applyStimulus(1, 3'b010, 32'(4*DEPTH + 16), 32'hFFFFFFFF, 32'h0, 1, 0, a0);
    applyStimulus(0, 3'b010, 32'(4*DEPTH), 32'h0, 32'h0, 1, 0, a0);
    applyStimulus(0, 3'b010, 32'h10, 32'h0, 32'h1234AAEF, 0, 0, a0);

    // req_valid held high across three requests
    applyStimulus(0, 3'b010, 32'h10, 32'h0, 32'h1234AAEF, 0, 1, a0);
    applyStimulus(0, 3'b000, 32'h12, 32'h0, 32'h34000000, 0, 1, a1);
    applyStimulus(0, 3'b101, 32'h10, 32'h0, 32'hAAEF0000, 0, 0, a2);
    checkOutput("accept_spacing_1", 32'(a1 - a0), 32'd3);
    checkOutput("accept_spacing_2", 32'(a2 - a1), 32'd3);
    drain();

    // Reset during ACCESS of a store abandons it
    applyStimulus(1, 3'b010, 32'h20, 32'h11223344, 32'h0, 0, 0, a0);
    drain();
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h20;
    req_wdata  = 32'h00000055;
    req_valid  = 1'b1;
    checkOutput("ready_before_abort", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", {31'b0, req_ready}, 32'd1);
    applyStimulus(0, 3'b010, 32'h20, 32'h0, 32'h11223344, 0, 0, a0);
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: time got %0t expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
